bayer_to_gray: RTL

Converts the raw Bayer pixel stream from the capture stage into the 12-bit grayscale stream consumed by the Sobel edge stage. Each 2x2 Bayer quad (G R / B G) is averaged into one gray pixel, so a RAW_W x RAW_H raw frame becomes a (RAW_W/2) x (RAW_H/2) gray frame (default 1280x960 -> 640x480 = 307200 pixels). Sits directly upstream of the Sobel stage: oDVAL/oGRAY drive its iDVAL/grayVal.

---
 rtl/bayer_to_gray.sv | 91 +++++++++
 1 files changed

// File: rtl/bayer_to_gray.sv
// Bayer quad (G R / B G) to 12-bit grayscale averager feeding the Sobel stage.
// Each 2x2 quad is summed across two raw lines through a half-width line buffer.
module bayer_to_gray #(
    parameter int RAW_W = 1280,
    parameter int RAW_H = 960,
    parameter int DW    = 12
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iFVAL,
    input  logic          iDVAL,
    input  logic [DW-1:0] iDATA,
    output logic          oDVAL,
    output logic [DW-1:0] oGRAY,
    output logic [9:0]    oX,
    output logic [9:0]    oY,
    output logic          oEOF
);

    localparam int XW = $clog2(RAW_W);
    localparam int YW = $clog2(RAW_H);
    localparam int AW = XW - 1;
    localparam int BW = DW + 1;

    logic [XW-1:0]   rx;
    logic [YW-1:0]   ry;
    logic [DW-1:0]   hold;
    logic [BW-1:0]   lbuf [RAW_W/2];
    logic [BW-1:0]   rd_q;
    logic            accept;
    logic            x_last;
    logic            y_last;
    logic            quad_done;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   pair_sum;
    logic [DW+1:0]   quad_sum;

    assign accept    = iFVAL && iDVAL;
    assign x_last    = (rx == XW'(RAW_W - 1));
    assign y_last    = (ry == YW'(RAW_H - 1));
    assign addr      = rx[XW-1:1];
    assign pair_sum  = {1'b0, hold} + {1'b0, iDATA};
    assign quad_sum  = {1'b0, rd_q} + {1'b0, pair_sum};
    assign quad_done = accept && rx[0] && ry[0];

    // Raw position counters; dropping iFVAL resynchronises to (0,0).
    always_ff @(posedge iCLK) begin
        if (iRST || !iFVAL) begin
            rx   <= '0;
            ry   <= '0;
            hold <= '0;
        end else if (iDVAL) begin
            if (!rx[0])
                hold <= iDATA;
            if (x_last) begin
                rx <= '0;
                ry <= y_last ? '0 : ry + 1'b1;
            end else begin
                rx <= rx + 1'b1;
            end
        end
    end

    // Even lines store pair sums; odd lines prefetch the matching entry on the
    // even pixel so it is ready (and held) when the odd pixel arrives.
    always_ff @(posedge iCLK) begin
        if (!iRST && accept && rx[0] && !ry[0])
            lbuf[addr] <= pair_sum;
        if (!iRST && accept && !rx[0] && ry[0])
            rd_q <= lbuf[addr];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDVAL <= 1'b0;
            oGRAY <= '0;
            oX    <= '0;
            oY    <= '0;
            oEOF  <= 1'b0;
        end else begin
            oDVAL <= quad_done;
            oEOF  <= quad_done && x_last && y_last;
            if (quad_done) begin
                oGRAY <= DW'(quad_sum >> 2);
                oX    <= 10'(rx >> 1);
                oY    <= 10'(ry >> 1);
            end
        end
    end

endmodule
